ex1_ex2_pipe_reg: RTL and testbench
===================================

// Module: ex1_ex2_pipe_reg
// PURPOSE
//  Dual-issue pipeline register between EX1 and EX2; feeds the EX2/WB stage.
//  Holds lane-0/lane-1 payloads and the lane-0 exception record under a valid/allowin handshake.
//  Owns the multi-cycle divider hold and flush-by-exception squash.
//  Lane 0 stays in EX2 until its divide completes.
// PARAMETERS
//  UOP_W     48            width of uop0/uop1 bundles
//  NOP_INST  32'h03400000  instruction word presented when the stage is empty or flushed
// PORTS
//  clk            in   1      clock
//  areset         in   1      reset; asynchronous, active-high
//  ex1_valid      in   1      EX1 holds a valid instruction pair
//  ex1_allowin    out  1      stage accepts a new pair this cycle
//  ex2_allowin    in   1      EX2/WB accepts the held pair (low while a load waits on dcache)
//  ex2_valid      out  1      held pair is presentable to EX2/WB
//  flush          in   1      flush_by_exception from WB; squashes the stage
//  pc0_i/pc1_i    in   32     lane PCs
//  inst0_i/inst1_i in  32     lane instruction words
//  uop0_i/uop1_i  in   UOP_W  lane uop bundles
//  res0_i/res1_i  in   32     EX1 ALU results
//  res0_v_i/res1_v_i in 1     result valid (writes rd)
//  rd0_i/rd1_i    in   5      destination registers
//  is_div0_i      in   1      lane 0 is a div/mod
//  exc_i          in   1      lane-0 exception flag
//  ecode_i        in   7      exception code
//  badv_i         in   32     bad virtual address
//  div_start      out  1      one-cycle pulse launching the divider
//  div_done       in   1      divider result valid (single-cycle pulse)
//  div_res        in   32     divider result
//  pc0/pc1, inst0/inst1, uop0/uop1, res0/res1, res0_v/res1_v, rd0/rd1, exc, ecode, badv
//                 out  as in  registered payload toward EX2/WB
// BEHAVIOUR
//  - Reset: v_r=0, busy=0; PCs, results, rd, ecode, badv, uops = 0; res*_v=0; exc=0;
//    inst0/inst1=NOP_INST; div_start=0. Reset mid-divide abandons the op; a late div_done is ignored.
//  - busy: lane 0 holds an in-flight divide.
//  - ex1_allowin = ~v_r | (ex2_allowin & ~busy). Purely combinational; no dependency on ex1_valid.
//  - ex2_valid = v_r & ~busy & ~flush.
//  - Capture (latency 1): ex1_valid & ex1_allowin & ~flush loads every payload field and sets v_r=1.
//  - Capture with exc_i=1 forces res1_v=0 and inst1=NOP_INST; lane 1 is never written behind an excepting lane 0.
//  - Drain: ex1_allowin & ~ex1_valid & v_r with no flush clears v_r, res0_v and res1_v.
//  - Divide:
//    - Capture with is_div0_i=1 and exc_i=0 sets busy=1 and res0_v=0.
//    - div_start pulses in the first cycle busy=1.
//    - div_done while busy: res0<=div_res, res0_v<=1, busy<=0. ex2_valid rises the following cycle.
//    - A div_done while not busy is ignored.
//  - FSM: EMPTY -(capture)-> FULL | DIV_WAIT; DIV_WAIT -(div_done)-> FULL;
//    FULL -(ex2_allowin & ~ex1_valid)-> EMPTY; FULL -(ex2_allowin & ex1_valid)-> FULL (back-to-back, no bubble).
//  - flush has priority over capture, drain and div_done in the same cycle. Next cycle:
//    - v_r=0, busy=0, exc=0, res*_v=0, inst*=NOP_INST.
//    - The divider result of a flushed op is dropped.
//  - ex2_allowin=0 while FULL: every output holds stable (no payload change) until accepted.
//  - Payload outputs remain driven while v_r=0; consumers qualify them with ex2_valid.
// CONFIGURATION
//  EX1_EX2_STALL_CNT_EN defined:
//    - Adds outputs stall_cnt[31:0] and div_cnt[31:0], both reset to 0, both wrapping at 2^32.
//    - stall_cnt increments each cycle v_r & ~ex2_allowin.
//    - div_cnt increments each cycle busy=1.
//    - Neither counter is cleared by flush.
//  Undefined: no counters and no extra ports; all other behaviour identical.
// TESTING
//  T1 Back-to-back: ex1_valid=1 and ex2_allowin=1 for 4 cycles, pc0=0x1c000000+8k
//     -> ex2_valid=1 from cycle 1; pc0 advances 0x1c000000, 0x1c000008, ... with no bubble.
//  T2 Backpressure: FULL with pc0=0x1c000010, ex2_allowin=0 for 3 cycles, ex1_valid=1
//     -> ex1_allowin=0; pc0 holds 0x1c000010. Next pair appears in the cycle after ex2_allowin returns to 1.
//  T3 Divide: capture is_div0_i=1, rd0=5; div_done arrives 8 cycles later with div_res=0x0000002a
//     -> div_start is a single pulse; ex2_valid=0 for 8 cycles, then 1 with res0=0x2a, res0_v=1, rd0=5.
//  T4 Flush mid-divide: flush=1 in the 3rd DIV_WAIT cycle, then div_done=1 2 cycles later
//     -> v_r=0, ex2_valid stays 0; inst0=0x03400000; the late div_done causes no change.
//  T5 Exception lane squash: capture exc_i=1, ecode_i=0x09, badv_i=0x1234, res1_v_i=1
//     -> exc=1, ecode=0x09, badv=0x1234, res1_v=0, inst1=0x03400000.
//  T6 Flush+capture same cycle, areset mid-FULL
//     -> stage empty next cycle (ex2_valid=0); areset immediately forces all reset values.
//     -> With EX1_EX2_STALL_CNT_EN defined, stall_cnt=0 after reset; otherwise the port is absent.

Source files
------------

// File: rtl/ex1_ex2_pipe_reg_if.sv
// ex1_ex2_pipe_reg_if: EX1-to-EX2 handshake, lane payloads and divider hooks
interface ex1_ex2_pipe_reg_if #(parameter int UOP_W = 48);
  logic ex1_valid, ex1_allowin, ex2_allowin, ex2_valid, flush;
  logic [31:0] pc0_i, pc1_i, inst0_i, inst1_i, res0_i, res1_i, badv_i;
  logic [UOP_W-1:0] uop0_i, uop1_i;
  logic res0_v_i, res1_v_i, is_div0_i, exc_i;
  logic [4:0] rd0_i, rd1_i;
  logic [6:0] ecode_i;
  logic div_start, div_done;
  logic [31:0] div_res;
  logic [31:0] pc0, pc1, inst0, inst1, res0, res1, badv;
  logic [UOP_W-1:0] uop0, uop1;
  logic res0_v, res1_v, exc;
  logic [4:0] rd0, rd1;
  logic [6:0] ecode;
  modport slave (
    input ex1_valid, ex2_allowin, flush, pc0_i, pc1_i, inst0_i, inst1_i, res0_i, res1_i,
          badv_i, uop0_i, uop1_i, res0_v_i, res1_v_i, is_div0_i, exc_i, rd0_i, rd1_i,
          ecode_i, div_done, div_res,
    output ex1_allowin, ex2_valid, div_start, pc0, pc1, inst0, inst1, res0, res1, badv,
           uop0, uop1, res0_v, res1_v, exc, rd0, rd1, ecode
  );
  modport master (
    output ex1_valid, ex2_allowin, flush, pc0_i, pc1_i, inst0_i, inst1_i, res0_i, res1_i,
           badv_i, uop0_i, uop1_i, res0_v_i, res1_v_i, is_div0_i, exc_i, rd0_i, rd1_i,
           ecode_i, div_done, div_res,
    input ex1_allowin, ex2_valid, div_start, pc0, pc1, inst0, inst1, res0, res1, badv,
          uop0, uop1, res0_v, res1_v, exc, rd0, rd1, ecode
  );
endinterface

// File: rtl/ex1_ex2_pipe_reg.sv
// ex1_ex2_pipe_reg: dual-issue EX1/EX2 pipeline register with divider hold and exception flush.
// Optional EX1_EX2_STALL_CNT_EN adds free-running stall_cnt/div_cnt performance counters.
module ex1_ex2_pipe_reg #(
  parameter int UOP_W = 48,
  parameter logic [31:0] NOP_INST = 32'h03400000
) (
  input logic clk,
  input logic areset,
  ex1_ex2_pipe_reg_if.slave p
`ifdef EX1_EX2_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] div_cnt
`endif
);
  typedef enum logic [1:0] {EMPTY, FULL, DIV_WAIT} state_t;
  state_t state;
  logic v_r, busy, cap, go_div;
  assign v_r = state != EMPTY;
  assign busy = state == DIV_WAIT;
  assign p.ex1_allowin = ~v_r | (p.ex2_allowin & ~busy);
  assign p.ex2_valid = v_r & ~busy & ~p.flush;
  assign cap = p.ex1_valid & p.ex1_allowin & ~p.flush;
  assign go_div = p.is_div0_i & ~p.exc_i;
  // Stage FSM and payload; flush outranks capture, divide completion and drain
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      state <= EMPTY;
      p.div_start <= 1'b0;
      p.pc0 <= '0;
      p.pc1 <= '0;
      p.inst0 <= NOP_INST;
      p.inst1 <= NOP_INST;
      p.uop0 <= {UOP_W{1'b0}};
      p.uop1 <= {UOP_W{1'b0}};
      p.res0 <= '0;
      p.res1 <= '0;
      p.res0_v <= 1'b0;
      p.res1_v <= 1'b0;
      p.rd0 <= '0;
      p.rd1 <= '0;
      p.exc <= 1'b0;
      p.ecode <= '0;
      p.badv <= '0;
    end else begin
      p.div_start <= cap & go_div;
      if (p.flush) begin
        state <= EMPTY;
        p.exc <= 1'b0;
        p.res0_v <= 1'b0;
        p.res1_v <= 1'b0;
        p.inst0 <= NOP_INST;
        p.inst1 <= NOP_INST;
      end else if (cap) begin
        state <= go_div ? DIV_WAIT : FULL;
        p.pc0 <= p.pc0_i;
        p.pc1 <= p.pc1_i;
        p.inst0 <= p.inst0_i;
        p.inst1 <= p.exc_i ? NOP_INST : p.inst1_i;
        p.uop0 <= p.uop0_i;
        p.uop1 <= p.uop1_i;
        p.res0 <= p.res0_i;
        p.res1 <= p.res1_i;
        p.res0_v <= p.res0_v_i & ~go_div;
        p.res1_v <= p.res1_v_i & ~p.exc_i;
        p.rd0 <= p.rd0_i;
        p.rd1 <= p.rd1_i;
        p.exc <= p.exc_i;
        p.ecode <= p.ecode_i;
        p.badv <= p.badv_i;
      end else if (busy & p.div_done) begin
        state <= FULL;
        p.res0 <= p.div_res;
        p.res0_v <= 1'b1;
      end else if (v_r & p.ex1_allowin & ~p.ex1_valid) begin
        state <= EMPTY;
        p.res0_v <= 1'b0;
        p.res1_v <= 1'b0;
      end
    end
`ifdef EX1_EX2_STALL_CNT_EN
  // Performance counters survive flush and wrap naturally
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      stall_cnt <= '0;
      div_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + {31'd0, v_r & ~p.ex2_allowin};
      div_cnt <= div_cnt + {31'd0, busy};
    end
`endif
endmodule

// File: tb/tb_ex1_ex2_pipe_reg.sv
// tb_ex1_ex2_pipe_reg: directed stimulus against a behavioural stage model checked every cycle
module tb_ex1_ex2_pipe_reg;
  localparam logic [31:0] NOP = 32'h03400000;
  localparam logic [31:0] BASE = 32'h1c000000;
  typedef struct packed {
    logic [31:0] pc0, pc1, inst0, inst1;
    logic [47:0] uop0, uop1;
    logic [31:0] res0, res1;
    logic res0_v, res1_v;
    logic [4:0] rd0, rd1;
    logic exc;
    logic [6:0] ecode;
    logic [31:0] badv;
  } pay_t;
  logic clk = 1'b0;
  logic areset;
  logic chk_en = 1'b0;
  int checks = 0;
  int errors = 0;
  ex1_ex2_pipe_reg_if #(.UOP_W(48)) bus();
`ifdef EX1_EX2_STALL_CNT_EN
  logic [31:0] stall_cnt, div_cnt;
  logic [31:0] m_stall, m_div;
`endif
  ex1_ex2_pipe_reg #(.UOP_W(48), .NOP_INST(NOP)) dut (
    .clk(clk),
    .areset(areset),
    .p(bus)
`ifdef EX1_EX2_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .div_cnt(div_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  // What the stage holds: whether a pair is present, whether lane 0 waits on the divider
  logic m_v, m_wait, m_start;
  pay_t m_p;
  function automatic pay_t captured();
    pay_t c;
    c.pc0 = bus.pc0_i; c.pc1 = bus.pc1_i; c.inst0 = bus.inst0_i;
    c.inst1 = bus.exc_i ? NOP : bus.inst1_i;
    c.uop0 = bus.uop0_i; c.uop1 = bus.uop1_i; c.res0 = bus.res0_i; c.res1 = bus.res1_i;
    c.res0_v = (bus.is_div0_i && !bus.exc_i) ? 1'b0 : bus.res0_v_i;
    c.res1_v = bus.exc_i ? 1'b0 : bus.res1_v_i;
    c.rd0 = bus.rd0_i; c.rd1 = bus.rd1_i; c.exc = bus.exc_i; c.ecode = bus.ecode_i; c.badv = bus.badv_i;
    return c;
  endfunction
  function automatic logic room();
    return !m_v || (bus.ex2_allowin && !m_wait);
  endfunction
  always @(posedge clk or posedge areset)
    if (areset) begin
      m_v <= 0; m_wait <= 0; m_start <= 0;
      m_p <= '{inst0: NOP, inst1: NOP, default: '0};
`ifdef EX1_EX2_STALL_CNT_EN
      m_stall <= 0; m_div <= 0;
`endif
    end else begin
`ifdef EX1_EX2_STALL_CNT_EN
      if (m_v && !bus.ex2_allowin) m_stall <= m_stall + 1;
      if (m_wait) m_div <= m_div + 1;
`endif
      m_start <= 0;
      if (bus.flush) begin
        m_v <= 0; m_wait <= 0;
        m_p.exc <= 0; m_p.res0_v <= 0; m_p.res1_v <= 0; m_p.inst0 <= NOP; m_p.inst1 <= NOP;
      end else if (bus.ex1_valid && room()) begin
        m_v <= 1;
        m_p <= captured();
        m_wait <= bus.is_div0_i && !bus.exc_i;
        m_start <= bus.is_div0_i && !bus.exc_i;
      end else if (m_wait && bus.div_done) begin
        m_wait <= 0; m_p.res0 <= bus.div_res; m_p.res0_v <= 1;
      end else if (m_v && room()) begin
        m_v <= 0; m_p.res0_v <= 0; m_p.res1_v <= 0;
      end
    end
  always @(negedge clk)
    if (chk_en) begin
      chk("ex1_allowin", bus.ex1_allowin, room());
      chk("ex2_valid", bus.ex2_valid, m_v && !m_wait && !bus.flush);
      chk("div_start", bus.div_start, m_start);
      chk("pc0", bus.pc0, m_p.pc0);
      chk("pc1", bus.pc1, m_p.pc1);
      chk("inst0", bus.inst0, m_p.inst0);
      chk("inst1", bus.inst1, m_p.inst1);
      chk("uop0", bus.uop0, m_p.uop0);
      chk("uop1", bus.uop1, m_p.uop1);
      chk("res0", bus.res0, m_p.res0);
      chk("res1", bus.res1, m_p.res1);
      chk("res_v", {bus.res0_v, bus.res1_v}, {m_p.res0_v, m_p.res1_v});
      chk("rd", {bus.rd0, bus.rd1}, {m_p.rd0, m_p.rd1});
      chk("exc_rec", {bus.exc, bus.ecode, bus.badv}, {m_p.exc, m_p.ecode, m_p.badv});
`ifdef EX1_EX2_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
      chk("div_cnt", div_cnt, m_div);
`endif
    end
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask
  task automatic load(input logic [31:0] pc, input logic div, input logic ex);
    bus.pc0_i = pc; bus.pc1_i = pc + 4;
    bus.inst0_i = pc ^ 32'h00001111; bus.inst1_i = pc ^ 32'h00002222;
    bus.uop0_i = {16'ha5a5, pc}; bus.uop1_i = {16'h5a5a, pc};
    bus.res0_i = pc + 1; bus.res1_i = pc + 2;
    bus.res0_v_i = 1; bus.res1_v_i = 1; bus.rd0_i = 5; bus.rd1_i = 7;
    bus.is_div0_i = div; bus.exc_i = ex;
    bus.ecode_i = ex ? 7'h09 : 7'h00; bus.badv_i = ex ? 32'h1234 : 32'h0;
  endtask
  initial begin
    areset = 1;
    bus.ex1_valid = 0; bus.ex2_allowin = 1; bus.flush = 0; bus.div_done = 0; bus.div_res = 0;
    load(BASE, 0, 0);
    cyc();
    chk("rst_pc0", bus.pc0, 0);
    chk("rst_inst0", bus.inst0, NOP);
    chk("rst_ex2_valid", bus.ex2_valid, 0);
    chk("rst_allowin", bus.ex1_allowin, 1);
    areset = 0;
    chk_en = 1;
    // back-to-back pairs, no bubble
    bus.ex1_valid = 1;
    for (int k = 0; k < 4; k++) begin
      load(BASE + 32'(8 * k), 0, 0);
      cyc();
      chk("t1_pc0", bus.pc0, BASE + 32'(8 * k));
      chk("t1_ex2_valid", bus.ex2_valid, 1);
    end
    // backpressure holds the pair
    load(BASE + 32'h10, 0, 0);
    cyc();
    bus.ex2_allowin = 0;
    load(BASE + 32'h20, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t2_pc0_hold", bus.pc0, BASE + 32'h10);
      chk("t2_allowin", bus.ex1_allowin, 0);
    end
    bus.ex2_allowin = 1;
    cyc();
    chk("t2_next_pc0", bus.pc0, BASE + 32'h20);
    bus.ex1_valid = 0;
    cyc();
    chk("t2_drain", bus.ex2_valid, 0);
    // divide with an 8-cycle latency
    bus.ex1_valid = 1;
    load(BASE + 32'h100, 1, 0);
    cyc();
    bus.ex1_valid = 0;
    chk("t3_start", bus.div_start, 1);
    chk("t3_wait", bus.ex2_valid, 0);
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("t3_start_once", bus.div_start, 0);
      chk("t3_wait", bus.ex2_valid, 0);
    end
    bus.div_done = 1; bus.div_res = 32'h2a;
    cyc();
    bus.div_done = 0;
    chk("t3_valid", bus.ex2_valid, 1);
    chk("t3_res0", bus.res0, 32'h2a);
    chk("t3_res0_v", bus.res0_v, 1);
    chk("t3_rd0", bus.rd0, 5);
    cyc();
    // flush during the divide, late div_done dropped
    bus.ex1_valid = 1;
    load(BASE + 32'h200, 1, 0);
    cyc();
    bus.ex1_valid = 0;
    cyc();
    cyc();
    bus.flush = 1;
    cyc();
    bus.flush = 0;
    chk("t4_inst0", bus.inst0, NOP);
    chk("t4_valid", bus.ex2_valid, 0);
    cyc();
    bus.div_done = 1; bus.div_res = 32'hdead;
    cyc();
    bus.div_done = 0;
    chk("t4_res0_kept", bus.res0, BASE + 32'h201);
    chk("t4_res0_v", bus.res0_v, 0);
    chk("t4_valid_late", bus.ex2_valid, 0);
    // exception squashes lane 1 and suppresses the divide
    bus.ex1_valid = 1;
    load(BASE + 32'h300, 0, 1);
    cyc();
    chk("t5_exc", bus.exc, 1);
    chk("t5_ecode", bus.ecode, 7'h09);
    chk("t5_badv", bus.badv, 32'h1234);
    chk("t5_res1_v", bus.res1_v, 0);
    chk("t5_inst1", bus.inst1, NOP);
    load(BASE + 32'h310, 1, 1);
    cyc();
    chk("t5_no_div", bus.div_start, 0);
    chk("t5_valid", bus.ex2_valid, 1);
    // flush beats capture, then async reset while stalled
    load(BASE + 32'h400, 0, 0);
    cyc();
    bus.flush = 1;
    load(BASE + 32'h500, 0, 0);
    cyc();
    bus.flush = 0;
    bus.ex1_valid = 0;
    chk("t6_flush_empty", bus.ex2_valid, 0);
    chk("t6_pc0_kept", bus.pc0, BASE + 32'h400);
    bus.ex1_valid = 1;
    bus.ex2_allowin = 0;
    load(BASE + 32'h600, 0, 0);
    cyc();
    cyc();
    areset = 1;
    #1;
    chk("t6_rst_pc0", bus.pc0, 0);
    chk("t6_rst_inst1", bus.inst1, NOP);
    chk("t6_rst_valid", bus.ex2_valid, 0);
`ifdef EX1_EX2_STALL_CNT_EN
    chk("t6_rst_stall_cnt", stall_cnt, 0);
`endif
    cyc();
    areset = 0;
    bus.ex1_valid = 0;
    bus.ex2_allowin = 1;
    cyc();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
